// File: rtl/imem_dmem_arbiter.sv
// imem_dmem_arbiter
//
// Shares one single-ported unified memory between the instruction-fetch (IF)
// stage and the data-memory (MEM) stage. A three-state FSM grants one requester
// at a time and drives a registered request/ready handshake to the memory. It
// generates byte lanes for byte accesses and returns one-cycle acks, read data
// and per-stage stall signals to the pipeline.
//
// Optional build macro: MEM_ARB_TIMEOUT_EN
//   Defined   - a 4-bit watchdog aborts a transfer whose m_ready never arrives.
//               The granted stage then gets an ack with zero read data, and
//               arb_err is set and held until reset.
//   Undefined - the FSM waits indefinitely for m_ready; arb_err is tied low.
//
// Ports
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   if_req/if_addr      fetch request (held until if_ack), word-aligned fetch
//   if_rdata/if_ack     fetched word, valid with the one-cycle if_ack pulse
//   dm_rw               01 = write, 10 = read, 00/11 = no request
//   dm_byte             1 = byte access (lbu/sb), 0 = word access
//   dm_addr/dm_wdata    data address, store data (byte stores use [7:0])
//   dm_rdata/dm_ack     load data (byte loads zero-extended), one-cycle ack
//   stall_if/stall_mem  stage is requesting and not being acked this cycle
//   m_req..m_wdata      registered memory request, held until m_ready
//   m_rdata/m_ready     memory read data and one-cycle completion
//   arb_err             sticky timeout flag (optional feature only)

module imem_dmem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  // Instruction fetch port
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  // Data memory port
  input  logic [1:0]        dm_rw,
  input  logic              dm_byte,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ack,
  // Pipeline stalls
  output logic              stall_if,
  output logic              stall_mem,
  // Unified memory port
  output logic              m_req,
  output logic              m_we,
  output logic [3:0]        m_be,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ready,
  // Error flag
  output logic              arb_err
);

  localparam logic [1:0] DmWrite = 2'b01;
  localparam logic [1:0] DmRead  = 2'b10;

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StFetch
  } state_e;

  state_e            state_q, state_d;
  logic              last_data_q, last_data_d;  // 1: last grant went to MEM
  logic              m_req_q, m_req_d;
  logic              m_we_q, m_we_d;
  logic [3:0]        m_be_q, m_be_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
  logic              byte_q, byte_d;
  logic [1:0]        lane_q, lane_d;
  logic              if_ack_q, if_ack_d;
  logic              dm_ack_q, dm_ack_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;

  logic              dm_valid;
  logic              grant_data;
  logic              grant_fetch;
  logic [7:0]        rd_byte;

`ifdef MEM_ARB_TIMEOUT_EN
  logic [3:0]        tmo_cnt_q, tmo_cnt_d;
  logic              arb_err_q, arb_err_d;
`endif

  // 11 is an illegal encoding from the control unit and is ignored.
  assign dm_valid = (dm_rw == DmWrite) || (dm_rw == DmRead);

  // Byte lane picked by the address latched at grant time.
  always_comb begin
    rd_byte = m_rdata[7:0];
    unique case (lane_q)
      2'd0: rd_byte = m_rdata[7:0];
      2'd1: rd_byte = m_rdata[15:8];
      2'd2: rd_byte = m_rdata[23:16];
      2'd3: rd_byte = m_rdata[31:24];
      default: rd_byte = m_rdata[7:0];
    endcase
  end

  always_comb begin
    state_d     = state_q;
    last_data_d = last_data_q;
    m_req_d     = m_req_q;
    m_we_d      = m_we_q;
    m_be_d      = m_be_q;
    m_addr_d    = m_addr_q;
    m_wdata_d   = m_wdata_q;
    byte_d      = byte_q;
    lane_d      = lane_q;
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    grant_data  = 1'b0;
    grant_fetch = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt_q;
    arb_err_d   = arb_err_q;
`endif

    unique case (state_q)
      StIdle: begin
        // The ack cycle is a dead cycle: the acked stage still shows its old
        // request, so arbitration waits until it has dropped or renewed it.
        if (!(if_ack_q || dm_ack_q)) begin
          if (dm_valid && (!if_req || !last_data_q)) begin
            grant_data = 1'b1;
          end else if (if_req) begin
            grant_fetch = 1'b1;
          end
        end

        if (grant_data) begin
          state_d     = StData;
          last_data_d = 1'b1;
          m_req_d     = 1'b1;
          m_we_d      = (dm_rw == DmWrite);
          byte_d      = dm_byte;
          lane_d      = dm_addr[1:0];
          if (dm_byte) begin
            m_be_d    = 4'b0001 << dm_addr[1:0];
            m_addr_d  = dm_addr;
            m_wdata_d = {4{dm_wdata[7:0]}};
          end else begin
            m_be_d    = 4'b1111;
            m_addr_d  = {dm_addr[ADDR_W-1:2], 2'b00};
            m_wdata_d = dm_wdata;
          end
        end else if (grant_fetch) begin
          state_d     = StFetch;
          last_data_d = 1'b0;
          m_req_d     = 1'b1;
          m_we_d      = 1'b0;
          m_be_d      = 4'b1111;
          m_addr_d    = {if_addr[ADDR_W-1:2], 2'b00};
          byte_d      = 1'b0;
        end

`ifdef MEM_ARB_TIMEOUT_EN
        if (grant_data || grant_fetch) begin
          tmo_cnt_d = 4'd0;
        end
`endif
      end

      StData, StFetch: begin
        if (m_ready) begin
          state_d = StIdle;
          m_req_d = 1'b0;
          if (state_q == StData) begin
            dm_ack_d = 1'b1;
            // Stores leave the last load value in place.
            if (!m_we_q) begin
              dm_rdata_d = byte_q ? {{(DATA_W-8){1'b0}}, rd_byte} : m_rdata;
            end
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = m_rdata;
          end
        end
`ifdef MEM_ARB_TIMEOUT_EN
        // Counter reaches 15 on this edge: abort and ack with zero data.
        else if (tmo_cnt_q == 4'd14) begin
          state_d   = StIdle;
          m_req_d   = 1'b0;
          tmo_cnt_d = 4'd15;
          arb_err_d = 1'b1;
          if (state_q == StData) begin
            dm_ack_d   = 1'b1;
            dm_rdata_d = '0;
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = '0;
          end
        end else begin
          tmo_cnt_d = tmo_cnt_q + 4'd1;
        end
`endif
      end

      default: begin
        state_d = StIdle;
        m_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      last_data_q <= 1'b0;
      m_req_q     <= 1'b0;
      m_we_q      <= 1'b0;
      m_be_q      <= 4'b0000;
      m_addr_q    <= '0;
      m_wdata_q   <= '0;
      byte_q      <= 1'b0;
      lane_q      <= 2'd0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      last_data_q <= last_data_d;
      m_req_q     <= m_req_d;
      m_we_q      <= m_we_d;
      m_be_q      <= m_be_d;
      m_addr_q    <= m_addr_d;
      m_wdata_q   <= m_wdata_d;
      byte_q      <= byte_d;
      lane_q      <= lane_d;
      if_ack_q    <= if_ack_d;
      dm_ack_q    <= dm_ack_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt_q <= 4'd0;
      arb_err_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      arb_err_q <= arb_err_d;
    end
  end

  assign arb_err = arb_err_q;
`else
  assign arb_err = 1'b0;
`endif

  assign m_req     = m_req_q;
  assign m_we      = m_we_q;
  assign m_be      = m_be_q;
  assign m_addr    = m_addr_q;
  assign m_wdata   = m_wdata_q;
  assign if_ack    = if_ack_q;
  assign dm_ack    = dm_ack_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign stall_if  = if_req && !if_ack_q;
  assign stall_mem = dm_valid && !dm_ack_q;

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Self-checking bench for imem_dmem_arbiter: directed cases followed by
// randomized traffic from both stages against a behavioural memory and a
// transaction-level arbitration model.

module tb_imem_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic [1:0]  dm_rw;
  logic        dm_byte;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ack;
  logic        stall_if;
  logic        stall_mem;
  logic        m_req;
  logic        m_we;
  logic [3:0]  m_be;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        m_ready;
  logic        arb_err;

  imem_dmem_arbiter #(
    .ADDR_W(32),
    .DATA_W(32)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_rdata (if_rdata),
    .if_ack   (if_ack),
    .dm_rw    (dm_rw),
    .dm_byte  (dm_byte),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_rdata (dm_rdata),
    .dm_ack   (dm_ack),
    .stall_if (stall_if),
    .stall_mem(stall_mem),
    .m_req    (m_req),
    .m_we     (m_we),
    .m_be     (m_be),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_rdata  (m_rdata),
    .m_ready  (m_ready),
    .arb_err  (arb_err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s (bound expired) t=%0t", name, $time);
  endtask

  // ---------------------------------------------------------------- memories
  logic [31:0] phys_mem [int unsigned];  // what the memory actually holds
  logic [31:0] ref_mem  [int unsigned];  // what the pipeline expects it holds

  function automatic logic [31:0] init_word(input int unsigned wa);
    return (wa * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] ref_word(input int unsigned wa);
    if (ref_mem.exists(wa)) return ref_mem[wa];
    return init_word(wa);
  endfunction

  // --------------------------------------------------------- memory responder
  int unsigned max_delay = 0;
  logic        no_ready  = 1'b0;

  initial begin
    int unsigned wait_left;
    int unsigned wa;
    logic [31:0] cur;
    m_ready   = 1'b0;
    m_rdata   = 32'h0;
    wait_left = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        m_ready   = 1'b0;
        wait_left = $urandom_range(0, max_delay);
      end else if (m_ready) begin
        m_ready   = 1'b0;
        m_rdata   = $urandom;
        wait_left = $urandom_range(0, max_delay);
      end else if (m_req && !no_ready) begin
        if (wait_left == 0) begin
          wa  = m_addr >> 2;
          cur = phys_mem.exists(wa) ? phys_mem[wa] : init_word(wa);
          if (m_we) begin
            for (int i = 0; i < 4; i++) begin
              if (m_be[i]) cur[8*i +: 8] = m_wdata[8*i +: 8];
            end
            phys_mem[wa] = cur;
          end
          m_rdata = cur;
          m_ready = 1'b1;
        end else begin
          wait_left--;
        end
      end
    end
  end

  // --------------------------------------------------------------- scoreboard
  typedef enum logic [1:0] {KNone, KFetch, KData} kind_e;
  typedef struct packed {
    logic        rd;
    logic [31:0] data;
  } dm_exp_t;

  logic [31:0] if_exp_q [$];
  dm_exp_t     dm_exp_q [$];
  kind_e       grant_log [$];

  // Transaction-level model of the arbiter as seen from outside.
  logic        exp_mreq = 1'b0;
  kind_e       exp_ack  = KNone;
  kind_e       granted  = KNone;
  logic        last_data = 1'b0;
  logic        e_we;
  logic [3:0]  e_be;
  logic [31:0] e_addr, e_amask, e_wdata;
  logic [31:0] hold_if = 32'h0;
  logic [31:0] hold_dm = 32'h0;

  always @(negedge clk) begin
    logic    pif, pdm;
    logic [31:0] ef;
    dm_exp_t ed;
    if (rst) begin
      exp_mreq  = 1'b0;
      exp_ack   = KNone;
      last_data = 1'b0;
      hold_if   = 32'h0;
      hold_dm   = 32'h0;
      check("rst_m_req", m_req, 1'b0);
      check("rst_m_we", m_we, 1'b0);
      check("rst_m_be", m_be, 4'h0);
      check("rst_m_addr", m_addr, 32'h0);
      check("rst_m_wdata", m_wdata, 32'h0);
      check("rst_if_ack", if_ack, 1'b0);
      check("rst_dm_ack", dm_ack, 1'b0);
      check("rst_if_rdata", if_rdata, 32'h0);
      check("rst_dm_rdata", dm_rdata, 32'h0);
      check("rst_arb_err", arb_err, 1'b0);
    end else begin
      pif = if_req;
      pdm = (dm_rw == 2'b01) || (dm_rw == 2'b10);
      check("m_req", m_req, exp_mreq);
      check("if_ack", if_ack, exp_ack == KFetch);
      check("dm_ack", dm_ack, exp_ack == KData);
      check("stall_if", stall_if, pif && (exp_ack != KFetch));
      check("stall_mem", stall_mem, pdm && (exp_ack != KData));
      check("arb_err", arb_err, 1'b0);
      if (exp_mreq) begin
        check("m_addr", m_addr & e_amask, e_addr & e_amask);
        check("m_we", m_we, e_we);
        check("m_be", m_be, e_be);
        if (e_we) check("m_wdata", m_wdata, e_wdata);
      end

      if (exp_ack == KFetch) begin
        if (if_exp_q.size() == 0) begin
          fail_now("if_ack_without_expectation");
        end else begin
          ef = if_exp_q.pop_front();
          check("if_rdata", if_rdata, ef);
          hold_if = ef;
        end
      end else begin
        check("if_rdata_hold", if_rdata, hold_if);
      end

      if (exp_ack == KData) begin
        if (dm_exp_q.size() == 0) begin
          fail_now("dm_ack_without_expectation");
        end else begin
          ed = dm_exp_q.pop_front();
          if (ed.rd) begin
            check("dm_rdata", dm_rdata, ed.data);
            hold_dm = ed.data;
          end else begin
            check("dm_rdata_hold_on_store", dm_rdata, hold_dm);
          end
        end
      end else begin
        check("dm_rdata_hold", dm_rdata, hold_dm);
      end

      // Advance the model by one cycle.
      if (exp_ack != KNone) begin
        exp_ack = KNone;
      end else if (exp_mreq) begin
        if (m_ready) begin
          exp_mreq = 1'b0;
          exp_ack  = granted;
        end
      end else if (pif || pdm) begin
        granted   = (pdm && (!pif || !last_data)) ? KData : KFetch;
        last_data = (granted == KData);
        grant_log.push_back(granted);
        exp_mreq  = 1'b1;
        if (granted == KData) begin
          e_we    = (dm_rw == 2'b01);
          e_be    = dm_byte ? (4'b0001 << dm_addr[1:0]) : 4'b1111;
          e_addr  = dm_byte ? dm_addr : {dm_addr[31:2], 2'b00};
          e_amask = dm_byte ? 32'hFFFF_FFFC : 32'hFFFF_FFFF;
          e_wdata = dm_byte ? {4{dm_wdata[7:0]}} : dm_wdata;
        end else begin
          e_we    = 1'b0;
          e_be    = 4'b1111;
          e_addr  = {if_addr[31:2], 2'b00};
          e_amask = 32'hFFFF_FFFF;
          e_wdata = 32'h0;
        end
      end
    end
  end

  // ------------------------------------------------------------ stage drivers
  task automatic do_fetch(input logic [31:0] a, output int lat);
    if_exp_q.push_back(ref_word(a >> 2));
    if_addr = a;
    if_req  = 1'b1;
    lat = 0;
    forever begin
      @(negedge clk);
      if (if_ack) break;
      lat++;
      if (lat >= 200) begin
        fail_now("if_ack_wait");
        break;
      end
    end
    @(posedge clk);
    #1;
    if_req = 1'b0;
  endtask

  task automatic do_dm(input logic [1:0] rw, input logic byt, input logic [31:0] a,
                       input logic [31:0] wd, output int lat);
    dm_exp_t     e;
    int unsigned wa;
    logic [31:0] w;
    wa = a >> 2;
    w  = ref_word(wa);
    if (rw == 2'b01) begin
      if (byt) w[8*a[1:0] +: 8] = wd[7:0];
      else w = wd;
      ref_mem[wa] = w;
      e.rd   = 1'b0;
      e.data = 32'h0;
    end else begin
      e.rd   = 1'b1;
      e.data = byt ? {24'h0, w[8*a[1:0] +: 8]} : w;
    end
    dm_exp_q.push_back(e);
    dm_rw    = rw;
    dm_byte  = byt;
    dm_addr  = a;
    dm_wdata = wd;
    lat = 0;
    forever begin
      @(negedge clk);
      if (dm_ack) break;
      lat++;
      if (lat >= 200) begin
        fail_now("dm_ack_wait");
        break;
      end
    end
    @(posedge clk);
    #1;
    dm_rw = 2'b00;
  endtask

  task automatic wait_mreq(input string name);
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (m_req) break;
      n++;
      if (n >= 20) begin
        fail_now(name);
        break;
      end
    end
  endtask

  // ------------------------------------------------------------------- stimulus
  initial begin
    int lat;
    rst      = 1'b1;
    if_req   = 1'b0;
    if_addr  = 32'h0;
    dm_rw    = 2'b00;
    dm_byte  = 1'b0;
    dm_addr  = 32'h0;
    dm_wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset while a fetch is on the bus aborts it without an ack.
    no_ready = 1'b1;
    if_addr  = 32'h0000_1040;
    if_req   = 1'b1;
    wait_mreq("mreq_before_reset");
    #3 rst = 1'b1;
    #1;
    check("reset_abort_m_req", m_req, 1'b0);
    check("reset_abort_if_ack", if_ack, 1'b0);
    check("reset_abort_arb_err", arb_err, 1'b0);
    @(posedge clk);
    #1 if_req = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    no_ready = 1'b0;
    check("post_reset_m_req", m_req, 1'b0);

    // Word fetch from an unaligned address.
    phys_mem[32'h100 >> 2] = 32'hDEAD_BEEF;
    ref_mem[32'h100 >> 2]  = 32'hDEAD_BEEF;
    do_fetch(32'h0000_0103, lat);
    check("fetch_latency", lat, 2);
    check("fetch_rdata_after", if_rdata, 32'hDEAD_BEEF);

    // Byte store to lane 2.
    do_dm(2'b01, 1'b1, 32'h0000_0006, 32'h1234_5678, lat);
    check("sb_latency", lat, 2);
    check("sb_mem_lane2", phys_mem[1] & 32'h00FF_0000, 32'h0078_0000);

    // Byte load from lane 3.
    phys_mem[1] = 32'hA1B2_C3D4;
    ref_mem[1]  = 32'hA1B2_C3D4;
    do_dm(2'b10, 1'b1, 32'h0000_0007, 32'h0, lat);
    check("lbu_rdata_after", dm_rdata, 32'h0000_00A1);

    // dm_rw = 11 is not a request.
    dm_rw   = 2'b11;
    dm_addr = 32'h0000_0010;
    repeat (5) @(posedge clk);
    #1;
    check("rw11_no_req", m_req, 1'b0);
    dm_rw = 2'b00;

    // Fetch dropped after grant still completes and acks.
    if_exp_q.push_back(ref_word(32'h1234 >> 2));
    if_addr  = 32'h0000_1234;
    if_req   = 1'b1;
    no_ready = 1'b1;
    wait_mreq("mreq_drop_case");
    @(posedge clk);
    #1 if_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 no_ready = 1'b0;
    lat = 0;
    forever begin
      @(negedge clk);
      if (if_ack) break;
      lat++;
      if (lat >= 20) begin
        fail_now("dropped_fetch_ack");
        break;
      end
    end
    @(posedge clk);
    #1;

    // Both stages held continuously after reset: DATA, FETCH, DATA, FETCH.
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    grant_log.delete();
    fork
      begin
        int l1;
        for (int i = 0; i < 2; i++) do_fetch(32'h0000_1000 + 32'(i * 4), l1);
      end
      begin
        int l2;
        for (int i = 0; i < 2; i++) do_dm(2'b10, 1'b0, 32'h0000_0020 + 32'(i * 4), 32'h0, l2);
      end
    join
    check("alt_grant_count", grant_log.size(), 4);
    for (int i = 0; i < grant_log.size() && i < 4; i++) begin
      check($sformatf("alt_grant_%0d", i), grant_log[i], (i % 2 == 0) ? KData : KFetch);
    end

    // Randomized traffic from both stages.
    max_delay = 3;
    fork
      begin
        int l3;
        int unsigned g;
        for (int i = 0; i < 30; i++) begin
          g = $urandom_range(0, 3);
          if (g > 0) begin
            repeat (g) @(posedge clk);
            #1;
          end
          do_fetch($urandom_range(32'h1000, 32'h1FFF), l3);
        end
      end
      begin
        int l4;
        int unsigned g;
        logic [1:0] rw;
        for (int i = 0; i < 30; i++) begin
          g = $urandom_range(0, 3);
          if (g > 0) begin
            dm_rw   = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00;
            dm_addr = $urandom_range(0, 63);
            repeat (g) @(posedge clk);
            #1 dm_rw = 2'b00;
          end
          rw = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10;
          do_dm(rw, 1'($urandom_range(0, 1)), $urandom_range(0, 63), $urandom, l4);
        end
      end
    join

    repeat (5) @(posedge clk);
    check("if_queue_drained", if_exp_q.size(), 0);
    check("dm_queue_drained", dm_exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog expired t=%0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
